// File: rtl/vga_timing_generator.sv
// Raster timing for VGA: 1-based HCNT/VCNT, HS/VS, IAA, line/frame pulses; optional FRAME_CNT via VGA_FRAME_COUNTER_EN.
// Latency: all outputs registered together from next-state counters, so decodes always match the counters shown.
// Backpressure: EN=0 freezes every counter and output; LINE_START/FRAME_START drop to 0 while stalled.
module vga_timing_generator #(
    parameter int   H_VISIBLE       = 640,
    parameter int   H_FRONT_PORCH   = 16,
    parameter int   H_SYNC_WIDTH    = 96,
    parameter int   H_BACK_PORCH    = 48,
    parameter int   V_VISIBLE       = 480,
    parameter int   V_FRONT_PORCH   = 10,
    parameter int   V_SYNC_WIDTH    = 2,
    parameter int   V_BACK_PORCH    = 33,
    parameter logic HS_ACTIVE_LEVEL = 1'b0,
    parameter logic VS_ACTIVE_LEVEL = 1'b0
) (
    input  logic        VGA_CLK,
    input  logic        rst,
    input  logic        EN,
    output logic [10:0] HCNT,
    output logic [10:0] VCNT,
    output logic        HS,
    output logic        VS,
    output logic        IAA,
    output logic        LINE_START,
    output logic        FRAME_START
`ifdef VGA_FRAME_COUNTER_EN
    ,
    output logic [15:0] FRAME_CNT
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

    localparam logic [10:0] H_TOT    = 11'(H_TOTAL);
    localparam logic [10:0] V_TOT    = 11'(V_TOTAL);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_FIRST = 11'(H_VISIBLE + H_FRONT_PORCH + 1);
    localparam logic [10:0] HS_LAST  = 11'(H_VISIBLE + H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam logic [10:0] VS_FIRST = 11'(V_VISIBLE + V_FRONT_PORCH + 1);
    localparam logic [10:0] VS_LAST  = 11'(V_VISIBLE + V_FRONT_PORCH + V_SYNC_WIDTH);

    if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_timing
        $error("vga_timing_generator: H_TOTAL/V_TOTAL must fit in 11 bits");
    end

    logic        h_wrap;
    logic        v_wrap;
    logic [10:0] h_nxt;
    logic [10:0] v_nxt;

    always_comb begin
        h_wrap = (HCNT == H_TOT);
        v_wrap = (VCNT == V_TOT);
        h_nxt  = h_wrap ? 11'd1 : HCNT + 11'd1;
        v_nxt  = VCNT;
        if (h_wrap) begin
            v_nxt = v_wrap ? 11'd1 : VCNT + 11'd1;
        end
    end

    // Decodes use the next-state counters so HS/VS/IAA land on the same edge as HCNT/VCNT.
    always_ff @(posedge VGA_CLK or posedge rst) begin
        if (rst) begin
            HCNT        <= 11'd1;
            VCNT        <= 11'd1;
            HS          <= ~HS_ACTIVE_LEVEL;
            VS          <= ~VS_ACTIVE_LEVEL;
            IAA         <= 1'b1;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
        end else if (EN) begin
            HCNT        <= h_nxt;
            VCNT        <= v_nxt;
            HS          <= (h_nxt >= HS_FIRST && h_nxt <= HS_LAST) ? HS_ACTIVE_LEVEL : ~HS_ACTIVE_LEVEL;
            VS          <= (v_nxt >= VS_FIRST && v_nxt <= VS_LAST) ? VS_ACTIVE_LEVEL : ~VS_ACTIVE_LEVEL;
            IAA         <= (h_nxt <= H_VIS) && (v_nxt <= V_VIS);
            LINE_START  <= h_wrap;
            FRAME_START <= h_wrap && v_wrap;
        end else begin
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
        end
    end

`ifdef VGA_FRAME_COUNTER_EN
    always_ff @(posedge VGA_CLK or posedge rst) begin
        if (rst) begin
            FRAME_CNT <= 16'd0;
        end else if (EN && h_wrap && v_wrap) begin
            FRAME_CNT <= FRAME_CNT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: default-timing instance for line-level checks, small-timing instance for frame-level checks.
module tb_vga_timing_generator;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        iaa;
        logic        ls;
        logic        fs;
    } out_t;

    typedef struct {
        int hv, hf, hw, hb;
        int vv, vf, vw, vb;
        bit hpol, vpol;
    } cfg_t;

    typedef struct {
        int          adv;
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        iaa;
        logic        ls;
    } vec_t;

    localparam cfg_t CFG_D = '{hv: 640, hf: 16, hw: 96, hb: 48, vv: 480, vf: 10, vw: 2, vb: 33, hpol: 1'b0, vpol: 1'b0};
    localparam cfg_t CFG_S = '{hv: 8, hf: 2, hw: 3, hb: 2, vv: 4, vf: 1, vw: 2, vb: 1, hpol: 1'b1, vpol: 1'b1};

    logic VGA_CLK = 1'b0;
    logic rst;
    logic en_d = 1'b0;
    logic en_s = 1'b0;

    logic [10:0] hcnt_d, vcnt_d, hcnt_s, vcnt_s;
    logic hs_d, vs_d, iaa_d, ls_d_o, fs_d_o;
    logic hs_s, vs_s, iaa_s, ls_s_o, fs_s_o;
`ifdef VGA_FRAME_COUNTER_EN
    logic [15:0] fc_d_o, fc_s_o;
`endif

    always #5 VGA_CLK = ~VGA_CLK;

    vga_timing_generator dut_d (
        .VGA_CLK(VGA_CLK), .rst(rst), .EN(en_d),
        .HCNT(hcnt_d), .VCNT(vcnt_d), .HS(hs_d), .VS(vs_d), .IAA(iaa_d),
        .LINE_START(ls_d_o), .FRAME_START(fs_d_o)
`ifdef VGA_FRAME_COUNTER_EN
        , .FRAME_CNT(fc_d_o)
`endif
    );

    vga_timing_generator #(
        .H_VISIBLE(8), .H_FRONT_PORCH(2), .H_SYNC_WIDTH(3), .H_BACK_PORCH(2),
        .V_VISIBLE(4), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(2), .V_BACK_PORCH(1),
        .HS_ACTIVE_LEVEL(1'b1), .VS_ACTIVE_LEVEL(1'b1)
    ) dut_s (
        .VGA_CLK(VGA_CLK), .rst(rst), .EN(en_s),
        .HCNT(hcnt_s), .VCNT(vcnt_s), .HS(hs_s), .VS(vs_s), .IAA(iaa_s),
        .LINE_START(ls_s_o), .FRAME_START(fs_s_o)
`ifdef VGA_FRAME_COUNTER_EN
        , .FRAME_CNT(fc_s_o)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: a linear pixel index per instance, decoded with plain arithmetic.
    int          p_d, p_s;
    bit          ls_d, ls_s;
    logic [15:0] fc_d, fc_s;
    int          ls_cnt_d;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic out_t model_out(input cfg_t c, input int p, input bit ls);
        out_t o;
        int ht = c.hv + c.hf + c.hw + c.hb;
        int h  = p % ht + 1;
        int v  = p / ht + 1;
        o.h   = 11'(h);
        o.v   = 11'(v);
        o.hs  = (h >= c.hv + c.hf + 1 && h <= c.hv + c.hf + c.hw) ? c.hpol : !c.hpol;
        o.vs  = (v >= c.vv + c.vf + 1 && v <= c.vv + c.vf + c.vw) ? c.vpol : !c.vpol;
        o.iaa = (h <= c.hv) && (v <= c.vv);
        o.ls  = ls;
        o.fs  = ls && (p == 0);
        return o;
    endfunction

    task automatic step(input cfg_t c, input bit en, inout int p, inout bit ls, inout logic [15:0] fc);
        int ht = c.hv + c.hf + c.hw + c.hb;
        int vt = c.vv + c.vf + c.vw + c.vb;
        if (en) begin
            p  = (p + 1) % (ht * vt);
            ls = (p % ht == 0);
            if (ls && p == 0) fc = fc + 16'd1;
        end else begin
            ls = 1'b0;
        end
    endtask

    task automatic model_reset();
        p_d = 0; p_s = 0; ls_d = 0; ls_s = 0; fc_d = 16'd0; fc_s = 16'd0;
    endtask

    task automatic compare();
        out_t a;
        a = {hcnt_d, vcnt_d, hs_d, vs_d, iaa_d, ls_d_o, fs_d_o};
        chk("model_d", 64'(a), 64'(model_out(CFG_D, p_d, ls_d)));
        a = {hcnt_s, vcnt_s, hs_s, vs_s, iaa_s, ls_s_o, fs_s_o};
        chk("model_s", 64'(a), 64'(model_out(CFG_S, p_s, ls_s)));
`ifdef VGA_FRAME_COUNTER_EN
        chk("frame_cnt_d", 64'(fc_d_o), 64'(fc_d));
        chk("frame_cnt_s", 64'(fc_s_o), 64'(fc_s));
`endif
        if (ls_d_o) ls_cnt_d++;
    endtask

    task automatic tick();
        @(posedge VGA_CLK);
        if (rst) begin
            model_reset();
        end else begin
            step(CFG_D, en_d, p_d, ls_d, fc_d);
            step(CFG_S, en_s, p_s, ls_s, fc_s);
        end
        #1;
        compare();
    endtask

    // Asynchronous assertion checked before any edge, held over one edge, released away from the edge.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        compare();
        tick();
        rst = 1'b0;
        ls_cnt_d = 0;
    endtask

    initial begin
        vec_t tbl[10];
        out_t snap;
        int done, vs_cnt, iaa_bad, fs_cnt;

        tbl[0] = '{adv: 0,   h: 11'd1,   v: 11'd1, hs: 1'b1, iaa: 1'b1, ls: 1'b0};
        tbl[1] = '{adv: 1,   h: 11'd2,   v: 11'd1, hs: 1'b1, iaa: 1'b1, ls: 1'b0};
        tbl[2] = '{adv: 639, h: 11'd640, v: 11'd1, hs: 1'b1, iaa: 1'b1, ls: 1'b0};
        tbl[3] = '{adv: 640, h: 11'd641, v: 11'd1, hs: 1'b1, iaa: 1'b0, ls: 1'b0};
        tbl[4] = '{adv: 656, h: 11'd657, v: 11'd1, hs: 1'b0, iaa: 1'b0, ls: 1'b0};
        tbl[5] = '{adv: 751, h: 11'd752, v: 11'd1, hs: 1'b0, iaa: 1'b0, ls: 1'b0};
        tbl[6] = '{adv: 752, h: 11'd753, v: 11'd1, hs: 1'b1, iaa: 1'b0, ls: 1'b0};
        tbl[7] = '{adv: 799, h: 11'd800, v: 11'd1, hs: 1'b1, iaa: 1'b0, ls: 1'b0};
        tbl[8] = '{adv: 800, h: 11'd1,   v: 11'd2, hs: 1'b1, iaa: 1'b1, ls: 1'b1};
        tbl[9] = '{adv: 801, h: 11'd2,   v: 11'd2, hs: 1'b1, iaa: 1'b1, ls: 1'b0};

        rst = 1'b1;
        do_reset();

        // Default timing, first line and wrap into line 2.
        en_d = 1'b1;
        done = 0;
        for (int i = 0; i < 10; i++) begin
            while (done < tbl[i].adv) begin
                tick();
                done++;
            end
            chk($sformatf("vec%0d_hcnt", i), 64'(hcnt_d), 64'(tbl[i].h));
            chk($sformatf("vec%0d_vcnt", i), 64'(vcnt_d), 64'(tbl[i].v));
            chk($sformatf("vec%0d_hs", i),   64'(hs_d),   64'(tbl[i].hs));
            chk($sformatf("vec%0d_iaa", i),  64'(iaa_d),  64'(tbl[i].iaa));
            chk($sformatf("vec%0d_ls", i),   64'(ls_d_o), 64'(tbl[i].ls));
        end
        chk("line_pulses_first_line", 64'(ls_cnt_d), 64'd1);

        // EN pattern 1,0,0,1 across the 800 -> 1 wrap.
        repeat (797) tick();
        chk("pre_toggle_hcnt", 64'(hcnt_d), 64'd799);
        ls_cnt_d = 0;
        tick();
        snap = {hcnt_d, vcnt_d, hs_d, vs_d, iaa_d, ls_d_o, fs_d_o};
        chk("toggle_h800", 64'(hcnt_d), 64'd800);
        en_d = 1'b0;
        tick();
        chk("stall1_hold", 64'({hcnt_d, vcnt_d, hs_d, vs_d, iaa_d, ls_d_o, fs_d_o}), 64'(snap));
        tick();
        chk("stall2_hold", 64'({hcnt_d, vcnt_d, hs_d, vs_d, iaa_d, ls_d_o, fs_d_o}), 64'(snap));
        en_d = 1'b1;
        tick();
        chk("toggle_wrap", 64'({hcnt_d, vcnt_d, ls_d_o}), 64'({11'd1, 11'd3, 1'b1}));
        en_d = 1'b0;
        tick();
        chk("toggle_ls_drop", 64'(ls_d_o), 64'd0);
        chk("toggle_ls_count", 64'(ls_cnt_d), 64'd1);

        // Reset in the middle of HS on the default instance.
        en_d = 1'b1;
        repeat (699) tick();
        chk("mid_hsync_pos", 64'({hcnt_d, vcnt_d, hs_d}), 64'({11'd700, 11'd3, 1'b0}));
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_d", 64'({hcnt_d, vcnt_d, hs_d, vs_d, iaa_d}), 64'({11'd1, 11'd1, 3'b111}));
        tick();
        rst = 1'b0;
        tick();
        chk("resume_d", 64'({hcnt_d, vcnt_d}), 64'({11'd2, 11'd1}));

        // Small timing: one whole frame with EN held high.
        en_d = 1'b0;
        en_s = 1'b1;
        do_reset();
        vs_cnt = 0; iaa_bad = 0; fs_cnt = 0;
        repeat (120) begin
            tick();
            if (vs_s) vs_cnt++;
            if (iaa_s && vcnt_s > 11'd4) iaa_bad++;
            if (fs_s_o) fs_cnt++;
        end
        chk("frame_vs_cycles", 64'(vs_cnt), 64'd30);
        chk("frame_iaa_blank", 64'(iaa_bad), 64'd0);
        chk("frame_start_count", 64'(fs_cnt), 64'd1);
        chk("frame_wrap_pos", 64'({hcnt_s, vcnt_s, fs_s_o}), 64'({11'd1, 11'd1, 1'b1}));
`ifdef VGA_FRAME_COUNTER_EN
        chk("fc_frame1", 64'(fc_s_o), 64'd1);
        repeat (120) tick();
        chk("fc_frame2", 64'({fc_s_o, fs_s_o}), 64'({16'd2, 1'b1}));
        repeat (120) tick();
        chk("fc_frame3", 64'({fc_s_o, fs_s_o}), 64'({16'd3, 1'b1}));
        repeat (50) tick();
        rst = 1'b1;
        model_reset();
        #1;
        chk("fc_async_rst", 64'(fc_s_o), 64'd0);
        tick();
        rst = 1'b0;
`endif

        // Small timing: reset while inside both HS and VS.
        do_reset();
        repeat (86) tick();
        chk("mid_sync_pos", 64'({hcnt_s, vcnt_s, hs_s, vs_s}), 64'({11'd12, 11'd6, 2'b11}));
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_s", 64'({hcnt_s, vcnt_s, hs_s, vs_s, iaa_s, ls_s_o, fs_s_o}),
            64'({11'd1, 11'd1, 2'b00, 1'b1, 2'b00}));
        tick();
        rst = 1'b0;
        tick();
        chk("resume_s", 64'({hcnt_s, vcnt_s}), 64'({11'd2, 11'd1}));

        // Random enables and occasional resets against the model.
        for (int i = 0; i < 3000; i++) begin
            en_d = ($urandom_range(0, 3) != 0);
            en_s = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 399) == 0) do_reset();
            else tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Upstream stage of the image generator: produces raster counters HCNT/VCNT, sync pulses HS/VS and the image-active-area flag IAA.
- The image generator consumes these to select colour data.
- Free-running raster scan at the pixel clock, gated by a pixel-enable input.
- Default timing is 640x480 @ 60 Hz with a 25 MHz VGA_CLK.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT_PORCH, 16, pixels between end of visible area and HS assertion
- H_SYNC_WIDTH, 96, HS pulse width in pixels
- H_BACK_PORCH, 48, pixels between HS deassertion and end of line
- V_VISIBLE, 480, visible lines per frame
- V_FRONT_PORCH, 10, lines between end of visible area and VS assertion
- V_SYNC_WIDTH, 2, VS pulse width in lines
- V_BACK_PORCH, 33, lines between VS deassertion and end of frame
- HS_ACTIVE_LEVEL, 0, level of HS while in sync pulse
- VS_ACTIVE_LEVEL, 0, level of VS while in sync pulse

Ports:
- VGA_CLK  input  1  pixel clock
- rst  input  1  asynchronous active-high reset
- EN  input  1  pixel enable; counters advance only when 1
- HCNT  output  11  horizontal position, 1..H_TOTAL
- VCNT  output  11  vertical position, 1..V_TOTAL
- HS  output  1  horizontal sync
- VS  output  1  vertical sync
- IAA  output  1  1 while (HCNT, VCNT) is inside the visible area
- LINE_START  output  1  one-cycle pulse when HCNT = 1
- FRAME_START  output  1  one-cycle pulse when HCNT = 1 and VCNT = 1

Behaviour:
- One clock domain. Reset is asynchronous and active-high; the clock port is VGA_CLK and the reset port is rst.
- H_TOTAL = sum of the four H parameters (default 800). V_TOTAL = sum of the four V parameters (default 525).
- Counters are 1-based. HCNT runs 1..H_TOTAL and VCNT runs 1..V_TOTAL. Value 0 never appears after reset release.
- Reset values:
  - HCNT = 1, VCNT = 1.
  - HS = ~HS_ACTIVE_LEVEL, VS = ~VS_ACTIVE_LEVEL.
  - IAA = 1, LINE_START = 0, FRAME_START = 0.
- Every output is a register, and all of them update on the same edge from the next-state counter values. HS, VS and IAA therefore always describe the HCNT/VCNT currently on the outputs, with zero skew between them.
- Advance rules, on a VGA_CLK edge with EN = 1:
  - HCNT < H_TOTAL: HCNT += 1.
  - HCNT = H_TOTAL: HCNT = 1, and VCNT advances.
  - VCNT advance with VCNT < V_TOTAL: VCNT += 1.
  - VCNT advance with VCNT = V_TOTAL: VCNT = 1, which starts a new frame.
- EN = 0: all counters and outputs hold their values. LINE_START and FRAME_START are forced to 0, so a pulse is never repeated across stalled cycles.
- Output decode:
  - IAA = (HCNT <= H_VISIBLE) && (VCNT <= V_VISIBLE).
  - HS active for H_VISIBLE+H_FRONT_PORCH+1 <= HCNT <= H_VISIBLE+H_FRONT_PORCH+H_SYNC_WIDTH. Default range is 657..752.
  - VS active for V_VISIBLE+V_FRONT_PORCH+1 <= VCNT <= V_VISIBLE+V_FRONT_PORCH+V_SYNC_WIDTH. Default range is 491..492. VS changes only on edges where HCNT wraps to 1.
  - LINE_START = 1 on the cycle HCNT becomes 1 with EN = 1.
  - FRAME_START = LINE_START && VCNT becomes 1.
  - After reset release, the first enabled edge moves HCNT to 2. No pulses occur until the first wrap.
- Reset asserted mid-line or mid-sync: outputs return to their reset values immediately, without waiting for a clock edge. Counting restarts from (1,1) on the first enabled edge after release.
- All comparisons and counters are 11-bit unsigned. A parameter set with H_TOTAL or V_TOTAL > 2047 is illegal and is flagged by an elaboration-time check.

Optional Feature:
- Macro: VGA_FRAME_COUNTER_EN.
- Defined: adds output FRAME_CNT (16 bits).
  - Reset value 0.
  - Increments by 1 on every edge where FRAME_START is set. The new value is visible in the same cycle as FRAME_START = 1.
  - Wraps from 65535 to 0.
- Undefined: the FRAME_CNT port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then EN = 1 for 800 cycles:
  - HCNT runs 1..800 and returns to 1.
  - VCNT steps 1 -> 2 exactly at the wrap.
  - LINE_START pulses exactly once, at the wrap.
- One full line with defaults:
  - IAA = 1 for HCNT 1..640 and 0 for HCNT 641..800 (on lines where VCNT <= 480).
  - HS = 0 exactly for HCNT 657..752; HS = 1 everywhere else.
- Full frame of 420000 enabled cycles:
  - VS = 0 only while VCNT is 491..492, i.e. 1600 cycles.
  - IAA = 0 for all of VCNT 481..525.
  - FRAME_START pulses once, at the (1,1) wrap.
- EN toggled 1,0,0,1 around the HCNT 800 -> 1 wrap:
  - All counters and outputs hold while EN = 0.
  - LINE_START is high for exactly one cycle.
- rst asserted at HCNT = 700, VCNT = 491:
  - Without waiting for a clock edge: HCNT = 1, VCNT = 1, HS = 1, VS = 1, IAA = 1.
  - After release, counting resumes from 2.
- VGA_FRAME_COUNTER_EN defined, 3 frames run:
  - FRAME_CNT reads 1, 2, 3, each coincident with FRAME_START.
  - A reset mid-frame returns FRAME_CNT to 0.
